// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
// Issue/writeback controller for an external combinational 16-bit ALU.
// It accepts one instruction at a time over a valid/ready handshake, reads
// its operands from an internal 4x16 register file, drives the ALU for one
// cycle, captures the result, and then writes it back along with the flags.
//
// Ports:
//   clk, rst_n       clock and asynchronous active-low reset
//   instr_valid/instr/instr_ready
//                    instruction handshake
//                      [15:12] op, [11:10] rd, [9:8] ra,
//                      [7] use_imm, [6:5] rb, [6:0] imm7
//   alu_a/alu_b/alu_op
//                    ALU operands; non-zero only during EXEC
//   alu_out/alu_flags
//                    ALU result and flags {ovf, sign, carry, zero}
//   res_valid        one-cycle completion pulse; res_data, res_flags and
//                    res_err are meaningful while it is high
//   flags_q          architectural flags register
//   dbg_addr/dbg_data
//                    combinational debug read port into the register file
// ---------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter int NREGS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [15:0] alu_out,
    input  logic [3:0]  alu_flags,
    output logic        res_valid,
    output logic [15:0] res_data,
    output logic [3:0]  res_flags,
    output logic        res_err,
    output logic [3:0]  flags_q,
    input  logic [1:0]  dbg_addr,
    output logic [15:0] dbg_data
);

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_rf [NREGS];
    logic [3:0]          r_op;
    logic [1:0]          r_rd;
    logic                r_err;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic                r_res_valid;
    logic [DATA_W-1:0]   r_res_data;
    logic [3:0]          r_res_flags;
    logic                r_res_err;
    logic [3:0]          r_flags;

    // Instruction field decode
    logic [3:0]          w_op;
    logic [1:0]          w_rd;
    logic [1:0]          w_ra;
    logic                w_use_imm;
    logic [1:0]          w_rb;
    logic [6:0]          w_imm7;
    logic                w_exec;

    assign w_op      = instr[15:12];
    assign w_rd      = instr[11:10];
    assign w_ra      = instr[9:8];
    assign w_use_imm = instr[7];
    assign w_rb      = instr[6:5];
    assign w_imm7    = instr[6:0];
    assign w_exec    = (r_state == S_EXEC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            for (int i = 0; i < NREGS; i++) begin
                r_rf[i] <= '0;
            end
            r_op        <= '0;
            r_rd        <= '0;
            r_err       <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_flags <= '0;
            r_res_err   <= 1'b0;
            r_flags     <= '0;
        end else begin
            case (r_state)
                // Accept edge: operands are latched here, so a later write to
                // rd == ra/rb cannot disturb this instruction.
                S_IDLE: begin
                    if (instr_valid) begin
                        r_op    <= w_op;
                        r_rd    <= w_rd;
                        r_err   <= w_op[3];  // opcodes 8..15 are illegal
                        r_a     <= r_rf[w_ra];
                        r_b     <= w_use_imm ? {9'b0, w_imm7} : r_rf[w_rb];
                        r_state <= S_EXEC;
                    end
                end
                // ALU is driven this cycle; capture its outputs at the edge.
                S_EXEC: begin
                    r_res_data  <= r_err ? '0 : alu_out;
                    r_res_flags <= r_err ? '0 : alu_flags;
                    r_res_err   <= r_err;
                    r_res_valid <= 1'b1;
                    r_state     <= S_WB;
                end
                // Completion cycle; commit architectural state at the edge.
                S_WB: begin
                    r_res_valid <= 1'b0;
                    if (!r_err) begin
                        r_rf[r_rd] <= r_res_data;
                        r_flags    <= r_res_flags;
                    end
                    r_state <= S_IDLE;
                end
                default: begin
                    r_res_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign instr_ready = (r_state == S_IDLE);

    // ALU inputs are forced to zero outside EXEC; an illegal op runs as PASS.
    assign alu_a  = w_exec ? r_a : '0;
    assign alu_b  = w_exec ? r_b : '0;
    assign alu_op = (w_exec && !r_err) ? r_op : 4'd0;

    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_flags = r_res_flags;
    assign res_err   = r_res_err;
    assign flags_q   = r_flags;
    assign dbg_data  = r_rf[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [15:0] alu_a, alu_b;
    logic [3:0]  alu_op;
    logic [15:0] alu_out;
    logic [3:0]  alu_flags;
    logic        res_valid;
    logic [15:0] res_data;
    logic [3:0]  res_flags;
    logic        res_err;
    logic [3:0]  flags_q;
    logic [1:0]  dbg_addr;
    logic [15:0] dbg_data;

    int errors = 0;
    int checks = 0;

    // Reference architectural state
    logic [15:0] m_rf [4];
    logic [3:0]  m_flags;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.NREGS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_out(alu_out), .alu_flags(alu_flags),
        .res_valid(res_valid), .res_data(res_data), .res_flags(res_flags),
        .res_err(res_err), .flags_q(flags_q),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Behavioural ALU: returns {ovf, sign, carry, zero, out}
    function automatic logic [19:0] alu_fn(input logic [3:0] op,
                                           input logic [15:0] a,
                                           input logic [15:0] b);
        logic [16:0] w;
        logic [15:0] o;
        logic        c;
        o = 16'h0;
        c = 1'b0;
        case (op)
            4'd0: o = b;
            4'd1: o = a | b;
            4'd2: o = a & b;
            4'd3: o = a ^ b;
            4'd4: o = ~a;
            4'd5: begin w = {1'b0, a} + {1'b0, b}; o = w[15:0]; c = w[16]; end
            4'd6: begin o = a - b; c = (a < b); end
            4'd7: begin o = {a[14:0], 1'b0}; c = a[15]; end
            default: o = 16'hDEAD;
        endcase
        return {1'b0, o[15], c, (o == 16'h0), o};
    endfunction

    always_comb begin
        {alu_flags, alu_out} = alu_fn(alu_op, alu_a, alu_b);
    end

    task automatic model_reset();
        for (int k = 0; k < 4; k++) m_rf[k] = 16'h0;
        m_flags = 4'h0;
    endtask

    // Architectural effect of one instruction on the reference state
    task automatic model_exec(input logic [15:0] ins, output logic [15:0] ed,
                              output logic [3:0] ef, output logic ee,
                              output logic [15:0] ea, output logic [15:0] eb);
        logic [3:0] op;
        op = ins[15:12];
        ea = m_rf[ins[9:8]];
        eb = ins[7] ? {9'b0, ins[6:0]} : m_rf[ins[6:5]];
        if (op > 4'd7) begin
            ee = 1'b1; ed = 16'h0; ef = 4'h0;
        end else begin
            ee = 1'b0;
            {ef, ed} = alu_fn(op, ea, eb);
            m_rf[ins[11:10]] = ed;
            m_flags = ef;
        end
    endtask

    // Drive one instruction and observe it through completion.
    // Returns at the negedge after the writeback edge.
    task automatic issue(input logic [15:0] ins, output int lat,
                         output logic [15:0] d, output logic [3:0] f,
                         output logic e, output logic [3:0] xop,
                         output logic [15:0] xa, output logic [15:0] xb,
                         output bit timeout);
        int n;
        timeout = 0; lat = 0; d = 0; f = 0; e = 0; xop = 0; xa = 0; xb = 0;
        @(negedge clk);
        instr = ins;
        instr_valid = 1'b1;
        n = 0;
        while (!instr_ready && n < 10) begin @(negedge clk); n++; end
        if (!instr_ready) begin
            timeout = 1; instr_valid = 1'b0; return;
        end
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        instr = 16'($urandom);
        xop = alu_op; xa = alu_a; xb = alu_b;
        lat = 1;
        while (!res_valid && lat < 6) begin @(negedge clk); lat++; end
        if (!res_valid) begin timeout = 1; return; end
        d = res_data; f = res_flags; e = res_err;
        @(negedge clk);
    endtask

    task automatic test_reset();
        int lat; logic [15:0] d, xa, xb; logic [3:0] f, xop; logic e; bit to;
        issue({4'h0, 2'd3, 2'd0, 1'b1, 7'h7F}, lat, d, f, e, xop, xa, xb, to);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", instr_ready); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
        checks++; if (flags_q !== 4'h0) begin errors++; $display("FAIL reset_flags: got %h expected 0", flags_q); end
        checks++; if ({alu_a, alu_b, alu_op} !== 36'h0) begin errors++; $display("FAIL reset_alu_ports: got %h expected 0", {alu_a, alu_b, alu_op}); end
        for (int k = 0; k < 4; k++) begin
            dbg_addr = 2'(k);
            #1;
            checks++; if (dbg_data !== 16'h0) begin errors++; $display("FAIL reset_rf%0d: got %h expected 0000", k, dbg_data); end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load_imm();
        int lat; logic [15:0] d, xa, xb, ed, ea, eb; logic [3:0] f, xop, ef; logic e, ee; bit to;
        logic [15:0] ins;
        ins = {4'h0, 2'd1, 2'd0, 1'b1, 7'h05};
        issue(ins, lat, d, f, e, xop, xa, xb, to);
        model_exec(ins, ed, ef, ee, ea, eb);
        checks++; if (to || lat != 2) begin errors++; $display("FAIL loadi_latency: got %0d (timeout %0d) expected 2", lat, to); end
        checks++; if (d !== 16'h0005) begin errors++; $display("FAIL loadi_res_data: got %h expected 0005", d); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL loadi_pulse_width: res_valid got %b expected 0", res_valid); end
        dbg_addr = 2'd1; #1;
        checks++; if (dbg_data !== 16'h0005) begin errors++; $display("FAIL loadi_r1: got %h expected 0005", dbg_data); end
        checks++; if (flags_q !== 4'h0) begin errors++; $display("FAIL loadi_flags: got %h expected 0", flags_q); end
    endtask

    task automatic test_arith_chain();
        int lat; logic [15:0] d, xa, xb, ed, ea, eb; logic [3:0] f, xop, ef; logic e, ee; bit to;
        logic [15:0] ins [3];
        logic [15:0] exp_r [3];
        logic [1:0]  exp_rd [3];
        ins[0] = {4'h5, 2'd2, 2'd1, 1'b0, 2'd1, 5'd0}; exp_rd[0] = 2'd2; exp_r[0] = 16'h000A;
        ins[1] = {4'h6, 2'd3, 2'd1, 1'b0, 2'd1, 5'd0}; exp_rd[1] = 2'd3; exp_r[1] = 16'h0000;
        ins[2] = {4'h7, 2'd2, 2'd2, 1'b0, 2'd0, 5'd0}; exp_rd[2] = 2'd2; exp_r[2] = 16'h0014;
        for (int i = 0; i < 3; i++) begin
            issue(ins[i], lat, d, f, e, xop, xa, xb, to);
            model_exec(ins[i], ed, ef, ee, ea, eb);
            dbg_addr = exp_rd[i]; #1;
            checks++; if (to || dbg_data !== exp_r[i]) begin errors++; $display("FAIL chain_step%0d: got %h expected %h", i, dbg_data, exp_r[i]); end
            if (i == 1) begin
                checks++; if (flags_q[0] !== 1'b1) begin errors++; $display("FAIL chain_sub_zero: got %b expected 1", flags_q[0]); end
            end
        end
    endtask

    task automatic test_illegal();
        int lat; logic [15:0] d, xa, xb, ed, ea, eb; logic [3:0] f, xop, ef; logic e, ee; bit to;
        logic [3:0] fl_before;
        fl_before = flags_q;
        issue({4'hF, 2'd1, 2'd2, 1'b0, 2'd2, 5'd0}, lat, d, f, e, xop, xa, xb, to);
        model_exec({4'hF, 2'd1, 2'd2, 1'b0, 2'd2, 5'd0}, ed, ef, ee, ea, eb);
        checks++; if (to || e !== 1'b1) begin errors++; $display("FAIL illegal_err: got %b expected 1", e); end
        checks++; if (d !== 16'h0 || f !== 4'h0) begin errors++; $display("FAIL illegal_result: got %h/%h expected 0000/0", d, f); end
        checks++; if (xop !== 4'h0) begin errors++; $display("FAIL illegal_alu_op: got %h expected 0", xop); end
        dbg_addr = 2'd1; #1;
        checks++; if (dbg_data !== 16'h0005) begin errors++; $display("FAIL illegal_r1: got %h expected 0005", dbg_data); end
        checks++; if (flags_q !== fl_before) begin errors++; $display("FAIL illegal_flags: got %h expected %h", flags_q, fl_before); end
    endtask

    task automatic test_handshake();
        logic [15:0] ins, ed, ea, eb; logic [3:0] ef; logic ee;
        int accepts, results, last, gap_bad;
        ins = {4'h5, 2'd0, 2'd1, 1'b0, 2'd1, 5'd0};
        accepts = 0; results = 0; last = -1; gap_bad = 0;
        @(negedge clk);
        instr = ins;
        instr_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (res_valid) results++;
            if (instr_ready) begin
                if (last >= 0 && c - last != 3) gap_bad++;
                last = c;
                accepts++;
                model_exec(ins, ed, ef, ee, ea, eb);
            end
            @(negedge clk);
        end
        instr_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (res_valid) results++;
            @(negedge clk);
        end
        checks++; if (accepts != 4) begin errors++; $display("FAIL hs_accepts: got %0d expected 4", accepts); end
        checks++; if (gap_bad != 0) begin errors++; $display("FAIL hs_spacing: got %0d bad gaps expected 0", gap_bad); end
        checks++; if (results != accepts) begin errors++; $display("FAIL hs_results: got %0d expected %0d", results, accepts); end
        dbg_addr = 2'd0; #1;
        checks++; if (dbg_data !== m_rf[0]) begin errors++; $display("FAIL hs_r0: got %h expected %h", dbg_data, m_rf[0]); end
    endtask

    task automatic test_reset_mid();
        int seen;
        seen = 0;
        @(negedge clk);
        instr = {4'h5, 2'd0, 2'd1, 1'b0, 2'd2, 5'd0};
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        checks++; if (alu_op !== 4'd5) begin errors++; $display("FAIL midrst_exec_op: got %h expected 5", alu_op); end
        #2 rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (res_valid) seen++;
            @(negedge clk);
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL midrst_res_valid: got %0d pulses expected 0", seen); end
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL midrst_idle: got %b expected 1", instr_ready); end
        dbg_addr = 2'd0; #1;
        checks++; if (dbg_data !== 16'h0) begin errors++; $display("FAIL midrst_r0: got %h expected 0000", dbg_data); end
    endtask

    task automatic test_random();
        int lat; logic [15:0] d, xa, xb, ed, ea, eb; logic [3:0] f, xop, ef; logic e, ee; bit to;
        logic [15:0] ins;
        logic [3:0] op;
        for (int i = 0; i < 40; i++) begin
            op = ($urandom_range(0, 4) == 0) ? 4'(8 + $urandom_range(0, 7)) : 4'($urandom_range(0, 7));
            ins = {op, 12'($urandom)};
            issue(ins, lat, d, f, e, xop, xa, xb, to);
            model_exec(ins, ed, ef, ee, ea, eb);
            checks++; if (to || lat != 2) begin errors++; $display("FAIL rnd%0d_latency: got %0d expected 2", i, lat); end
            checks++; if ({d, f, e} !== {ed, ef, ee}) begin errors++; $display("FAIL rnd%0d_result ins=%h: got %h/%h/%b expected %h/%h/%b", i, ins, d, f, e, ed, ef, ee); end
            checks++; if ({xop, xa, xb} !== {(ee ? 4'h0 : op), ea, eb}) begin errors++; $display("FAIL rnd%0d_alu_ports: got %h/%h/%h expected %h/%h/%h", i, xop, xa, xb, (ee ? 4'h0 : op), ea, eb); end
            checks++; if (flags_q !== m_flags) begin errors++; $display("FAIL rnd%0d_flags: got %h expected %h", i, flags_q, m_flags); end
            for (int k = 0; k < 4; k++) begin
                dbg_addr = 2'(k); #1;
                checks++; if (dbg_data !== m_rf[k]) begin errors++; $display("FAIL rnd%0d_r%0d: got %h expected %h", i, k, dbg_data, m_rf[k]); end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        instr_valid = 1'b0;
        instr = 16'h0;
        dbg_addr = 2'd0;
        model_reset();
        #12 rst_n = 1'b1;
        test_reset();
        test_load_imm();
        test_arith_chain();
        test_illegal();
        test_handshake();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
